cpu_control_unit: RTL

Multi-cycle fetch/decode/execute controller for the 8-bit CPU. It sits directly upstream of `alu`. It fetches 8-bit instructions over a request/valid memory handshake, reads operands from an internal 4x8 register file, and drives `a`/`b`/`alu_sel` into `alu`. It then writes `alu_out` back to the register file and updates a zero flag.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/cpu_control_unit_regfile.sv | 32 +++
 rtl/cpu_control_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: opcodes, FSM states, instruction field widths.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int DATA_W = 8;
   localparam int OPC_W  = 4;
   localparam int REG_W  = 2;
   localparam int NREGS  = 4;

   // ALU opcodes double as alu_sel values
   localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
   localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
   localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
   localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
   localparam logic [OPC_W-1:0] OP_XOR  = 4'h4;
   localparam logic [OPC_W-1:0] OP_NAND = 4'h5;
   localparam logic [OPC_W-1:0] OP_NOR  = 4'h6;
   localparam logic [OPC_W-1:0] OP_XNOR = 4'h7;
   localparam logic [OPC_W-1:0] OP_LDI  = 4'h8;
   localparam logic [OPC_W-1:0] OP_MOV  = 4'h9;
   localparam logic [OPC_W-1:0] OP_JMP  = 4'hA;
   localparam logic [OPC_W-1:0] OP_JZ   = 4'hB;
   localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_IMM    = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   // Opcodes 0x0-0x7 are the ALU group
   function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
      return ~op[OPC_W-1];
   endfunction

endpackage

// File: rtl/cpu_control_unit_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
// Latency: reads 0 cycles, writes visible the cycle after the write strobe.
// Backpressure: none; a write is always accepted.
module regfile4x8
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [REG_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_W-1:0]  raddr_a_i,
   input  logic [REG_W-1:0]  raddr_b_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o
);

   logic [DATA_W-1:0] regs_q [NREGS];

   // Storage: cleared on reset, single write per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute controller driving an external combinational ALU.
// Latency: ALU op 3 cycles, MOV/NOP 2, LDI/JMP/JZ 3, plus one per memory wait cycle.
// Backpressure: imem_req and imem_addr hold until imem_valid; FSM stalls in FETCH/IMM.
module cpu_control_unit
   import cpu_pkg::*;
#(
   parameter logic [7:0] PC_RESET = 8'h00
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_valid,
   input  logic [7:0] imem_data,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_sel,
   input  logic [7:0] alu_result,
   output logic       wb_en,
   output logic [1:0] wb_addr,
   output logic [7:0] wb_data,
   output logic       zero,
   output logic [7:0] pc,
   output logic       halted
);

   state_t            state_q;
   logic [7:0]        ir_q;
   logic [7:0]        pc_q;
   logic              req_q;
   logic [7:0]        alu_a_q;
   logic [7:0]        alu_b_q;
   logic [3:0]        alu_sel_q;
   logic              wb_en_q;
   logic [1:0]        wb_addr_q;
   logic [7:0]        wb_data_q;
   logic              zero_q;
   logic              halted_q;

   logic [OPC_W-1:0]  opcode;
   logic [REG_W-1:0]  rd;
   logic [REG_W-1:0]  rs;
   logic [7:0]        rd_val;
   logic [7:0]        rs_val;
   logic [7:0]        pc_inc;
   logic              rf_we;
   logic [7:0]        rf_wdata;

   assign opcode = ir_q[7:4];
   assign rd     = ir_q[3:2];
   assign rs     = ir_q[1:0];
   assign pc_inc = pc_q + 8'd1;

   regfile4x8 u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (rf_we),
      .waddr_i   (rd),
      .wdata_i   (rf_wdata),
      .raddr_a_i (rd),
      .raddr_b_i (rs),
      .rdata_a_o (rd_val),
      .rdata_b_o (rs_val)
   );

   // Write decision: MOV in DECODE, ALU result in EXEC, LDI immediate on IMM acceptance
   always_comb begin
      rf_we    = 1'b0;
      rf_wdata = alu_result;
      case (state_q)
         ST_DECODE: if (opcode == OP_MOV) begin
            rf_we    = 1'b1;
            rf_wdata = rs_val;
         end
         ST_EXEC:   rf_we = 1'b1;
         ST_IMM:    if (imem_valid && opcode == OP_LDI) begin
            rf_we    = 1'b1;
            rf_wdata = imem_data;
         end
         default:   ;
      endcase
   end

   // Main FSM with PC, IR and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ir_q      <= '0;
         pc_q      <= PC_RESET;
         req_q     <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= '0;
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         zero_q    <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         wb_en_q <= rf_we;
         if (rf_we) begin
            wb_addr_q <= rd;
            wb_data_q <= rf_wdata;
         end
         case (state_q)
            ST_IDLE: if (start) begin
               state_q <= ST_FETCH;
               req_q   <= 1'b1;
            end
            ST_FETCH: if (imem_valid) begin
               ir_q    <= imem_data;
               pc_q    <= pc_inc;
               req_q   <= 1'b0;
               state_q <= ST_DECODE;
            end
            ST_DECODE: begin
               if (is_alu_op(opcode)) begin
                  alu_a_q   <= rd_val;
                  alu_b_q   <= rs_val;
                  alu_sel_q <= opcode;
                  state_q   <= ST_EXEC;
               end else begin
                  case (opcode)
                     OP_LDI, OP_JMP, OP_JZ: begin
                        state_q <= ST_IMM;
                        req_q   <= 1'b1;
                     end
                     OP_HLT: begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                     end
                     default: begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                     end
                  endcase
               end
            end
            ST_EXEC: begin
               zero_q  <= (alu_result == 8'h00);
               state_q <= ST_FETCH;
               req_q   <= 1'b1;
            end
            ST_IMM: if (imem_valid) begin
               // The following FETCH keeps the request up, now at the updated PC
               case (opcode)
                  OP_JMP:  pc_q <= imem_data;
                  OP_JZ:   pc_q <= zero_q ? imem_data : pc_inc;
                  default: pc_q <= pc_inc;
               endcase
               state_q <= ST_FETCH;
            end
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign wb_en     = wb_en_q;
   assign wb_addr   = wb_addr_q;
   assign wb_data   = wb_data_q;
   assign zero      = zero_q;
   assign pc        = pc_q;
   assign halted    = halted_q;

endmodule
